fib_gen: RTL and testbench

FIB_GEN -- requirements
Module: fib_gen

---
 rtl/fib_gen.sv | 97 +++++++++
 tb/tb_fib_gen.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/fib_gen.sv
// Fibonacci term generator: seeds loaded on start, one term per enabled step, wrap or stop on overflow.
// Latency: one cycle from start to the first term. en=0 holds all state; there is no other backpressure.
module fib_gen #(
    parameter int WIDTH     = 4,
    parameter int IDX_W     = 8,
    parameter int MAX_TERMS = 0,
    parameter int WRAP_MODE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             en,
    input  logic [WIDTH-1:0] seed_a,
    input  logic [WIDTH-1:0] seed_b,
    output logic [WIDTH-1:0] out,
    output logic [IDX_W-1:0] index,
    output logic             valid,
    output logic             done,
    output logic             wrapped,
    output logic             overflow
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam int               LAST_I = (MAX_TERMS == 0) ? 0 : MAX_TERMS - 1;
    localparam logic [IDX_W-1:0] LAST   = LAST_I[IDX_W-1:0];

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [IDX_W-1:0] r_idx;
    logic             r_ovf_p;
    logic             r_ovf;
    logic             r_wrapped;

    logic [WIDTH:0]   w_sum;
    logic             w_last;

    // One extra bit so the carry out of the term width is visible as overflow.
    assign w_sum  = {1'b0, r_a} + {1'b0, r_b};
    assign w_last = (MAX_TERMS != 0) && (r_idx == LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            r_a       <= '0;
            r_b       <= '0;
            r_idx     <= '0;
            r_ovf_p   <= 1'b0;
            r_ovf     <= 1'b0;
            r_wrapped <= 1'b0;
        end else begin
            r_wrapped <= 1'b0;
            if (start) begin
                r_state <= S_RUN;
                r_a     <= seed_a;
                r_b     <= seed_b;
                r_idx   <= '0;
                r_ovf_p <= 1'b0;
                r_ovf   <= 1'b0;
            end else if (r_state == S_RUN && en) begin
                // Term-count limit wins over overflow handling.
                if (w_last) begin
                    r_state <= S_DONE;
                end else if (r_ovf_p) begin
                    if (WRAP_MODE != 0) begin
                        r_a       <= seed_a;
                        r_b       <= seed_b;
                        r_idx     <= '0;
                        r_ovf_p   <= 1'b0;
                        r_wrapped <= 1'b1;
                    end else begin
                        r_state <= S_DONE;
                    end
                end else begin
                    r_a   <= r_b;
                    r_b   <= w_sum[WIDTH-1:0];
                    r_idx <= r_idx + 1'b1;
                    if (w_sum[WIDTH]) begin
                        r_ovf_p <= 1'b1;
                        r_ovf   <= 1'b1;
                    end
                end
            end
        end
    end

    assign valid    = (r_state != S_IDLE);
    assign done     = (r_state == S_DONE);
    assign out      = valid ? r_a : '0;
    assign index    = r_idx;
    assign wrapped  = r_wrapped;
    assign overflow = r_ovf;

endmodule

// File: tb/tb_fib_gen.sv
// Directed bench for fib_gen: wrap, stop, term-limit, hold, async reset and start-over-en cases.
module tb_fib_gen;

    logic       clk;
    logic       rst;
    logic       start;
    logic       en;
    logic [3:0] seed_a;
    logic [3:0] seed_b;
    logic [7:0] seed_a8;
    logic [7:0] seed_b8;

    logic [3:0] out0, out1;
    logic [7:0] out2;
    logic [7:0] idx0, idx1, idx2;
    logic       vld0, vld1, vld2;
    logic       dn0, dn1, dn2;
    logic       wr0, wr1, wr2;
    logic       ov0, ov1, ov2;

    int checks   = 0;
    int failures = 0;

    int exp0_out [10] = '{1, 1, 2, 3, 5, 8, 13, 0, 1, 1};
    int exp0_idx [10] = '{1, 2, 3, 4, 5, 6, 7, 0, 1, 2};
    int exp1_out [10] = '{1, 1, 2, 3, 5, 8, 13, 13, 13, 13};
    int exp1_idx [10] = '{1, 2, 3, 4, 5, 6, 7, 7, 7, 7};
    int exp2_out [10] = '{3, 5, 8, 8, 8, 8, 8, 8, 8, 8};
    int exp2_idx [10] = '{1, 2, 3, 3, 3, 3, 3, 3, 3, 3};

    fib_gen #(.WIDTH(4), .IDX_W(8), .MAX_TERMS(0), .WRAP_MODE(1)) u_wrap (
        .clk(clk), .rst(rst), .start(start), .en(en), .seed_a(seed_a), .seed_b(seed_b),
        .out(out0), .index(idx0), .valid(vld0), .done(dn0), .wrapped(wr0), .overflow(ov0)
    );

    fib_gen #(.WIDTH(4), .IDX_W(8), .MAX_TERMS(0), .WRAP_MODE(0)) u_stop (
        .clk(clk), .rst(rst), .start(start), .en(en), .seed_a(seed_a), .seed_b(seed_b),
        .out(out1), .index(idx1), .valid(vld1), .done(dn1), .wrapped(wr1), .overflow(ov1)
    );

    fib_gen #(.WIDTH(8), .IDX_W(8), .MAX_TERMS(4), .WRAP_MODE(1)) u_lim (
        .clk(clk), .rst(rst), .start(start), .en(en), .seed_a(seed_a8), .seed_b(seed_b8),
        .out(out2), .index(idx2), .valid(vld2), .done(dn2), .wrapped(wr2), .overflow(ov2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        if (obs !== exp_v) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst     = 1'b0;
        start   = 1'b0;
        en      = 1'b0;
        seed_a  = 4'd0;
        seed_b  = 4'd1;
        seed_a8 = 8'd2;
        seed_b8 = 8'd3;
        #3;
        check("rst_out", 32'(out0), 0);
        check("rst_idx", 32'(idx0), 0);
        check("rst_valid", 32'(vld0), 0);
        check("rst_done", 32'(dn1), 0);
        check("rst_wrapped", 32'(wr0), 0);
        check("rst_overflow", 32'(ov0), 0);
        #4 rst = 1'b1;

        // en in IDLE is ignored
        en = 1'b1;
        tick();
        check("idle_en_valid", 32'(vld0), 0);
        check("idle_en_out", 32'(out0), 0);
        en = 1'b0;

        start = 1'b1;
        tick();
        start = 1'b0;
        check("start_out0", 32'(out0), 0);
        check("start_idx0", 32'(idx0), 0);
        check("start_valid0", 32'(vld0), 1);
        check("start_out2", 32'(out2), 2);

        en = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            check($sformatf("wrap_out[%0d]", i), 32'(out0), 32'(exp0_out[i]));
            check($sformatf("wrap_idx[%0d]", i), 32'(idx0), 32'(exp0_idx[i]));
            check($sformatf("wrap_pulse[%0d]", i), 32'(wr0), (i == 7) ? 1 : 0);
            check($sformatf("wrap_ovf[%0d]", i), 32'(ov0), (i >= 6) ? 1 : 0);
            check($sformatf("stop_out[%0d]", i), 32'(out1), 32'(exp1_out[i]));
            check($sformatf("stop_idx[%0d]", i), 32'(idx1), 32'(exp1_idx[i]));
            check($sformatf("stop_done[%0d]", i), 32'(dn1), (i >= 7) ? 1 : 0);
            check($sformatf("lim_out[%0d]", i), 32'(out2), 32'(exp2_out[i]));
            check($sformatf("lim_idx[%0d]", i), 32'(idx2), 32'(exp2_idx[i]));
            check($sformatf("lim_done[%0d]", i), 32'(dn2), (i >= 3) ? 1 : 0);
        end
        en = 1'b0;

        start = 1'b1;
        tick();
        start = 1'b0;
        check("restart_stop_out", 32'(out1), 0);
        check("restart_stop_idx", 32'(idx1), 0);
        check("restart_stop_done", 32'(dn1), 0);
        check("restart_stop_ovf", 32'(ov1), 0);
        check("restart_wrap_ovf", 32'(ov0), 0);

        // hold with en low mid-run
        en = 1'b1;
        repeat (5) tick();
        check("pre_hold_out", 32'(out0), 5);
        en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("hold_out[%0d]", i), 32'(out0), 5);
            check($sformatf("hold_idx[%0d]", i), 32'(idx0), 5);
        end
        en = 1'b1;
        tick();
        en = 1'b0;
        check("resume_out", 32'(out0), 8);
        check("resume_idx", 32'(idx0), 6);

        // async reset between edges
        #2 rst = 1'b0;
        #1;
        check("arst_out", 32'(out0), 0);
        check("arst_idx", 32'(idx0), 0);
        check("arst_valid", 32'(vld0), 0);
        #2 rst = 1'b1;
        tick();
        check("post_rst_idle", 32'(vld0), 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("post_rst_start_out", 32'(out0), 0);
        check("post_rst_start_valid", 32'(vld0), 1);

        // start has priority over en
        en = 1'b1;
        repeat (4) tick();
        check("pre_prio_out", 32'(out0), 3);
        seed_a = 4'd7;
        start  = 1'b1;
        tick();
        start = 1'b0;
        en    = 1'b0;
        check("prio_out", 32'(out0), 7);
        check("prio_idx", 32'(idx0), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
